// File: rtl/decode_inst_queue.sv
// Instruction queue between fetch and the dual-issue decoder: compacts masked fetch
// packets into a circular buffer and presents the two oldest entries. Optional same-cycle
// bypass when empty is enabled by defining DECODE_INST_QUEUE_BYPASS_EN.
module decode_inst_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_pc_i,
    input  logic [63:0]      in_insts_i,
    input  logic [1:0]       in_mask_i,
    input  logic [1:0]       in_excp_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [1:0]       out_mask_o,
    output logic [63:0]      out_pc_o,
    output logic [63:0]      out_insts_o,
    output logic [1:0]       out_excp_o,
    output logic [PTR_W:0]   count_o
);

    localparam logic [PTR_W:0] PUSH_LIMIT = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0] CNT_TWO    = (PTR_W+1)'(2);

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic             excp_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_ptr_p1, rd_ptr_p1;
    logic [PTR_W:0]   count;

    logic [31:0]      pk0_pc, pk1_pc, pk0_inst, pk1_inst;
    logic             pk0_excp, pk1_excp;
    logic [1:0]       in_n;
    logic [1:0]       pop_n;
    logic [1:0]       pres_mask;
    logic             byp_sel;
    logic             do_push, do_pop;

    assign wr_ptr_p1 = wr_ptr + 1'b1;
    assign rd_ptr_p1 = rd_ptr + 1'b1;
    assign count_o   = count;

    // Compact the packet: a lone slot 1 moves down into the first position.
    always_comb begin
        in_n     = {1'b0, in_mask_i[0]} + {1'b0, in_mask_i[1]};
        pk1_pc   = in_pc_i | 32'h4;
        pk1_inst = in_insts_i[63:32];
        pk1_excp = in_excp_i[1];
        if (in_mask_i[0]) begin
            pk0_pc   = in_pc_i;
            pk0_inst = in_insts_i[31:0];
            pk0_excp = in_excp_i[0];
        end else begin
            pk0_pc   = pk1_pc;
            pk0_inst = pk1_inst;
            pk0_excp = pk1_excp;
        end
    end

    assign in_ready_o = !rst && !flush_i && (count <= PUSH_LIMIT);

`ifdef DECODE_INST_QUEUE_BYPASS_EN
    assign byp_sel = !rst && (count == '0) && !flush_i;
`else
    assign byp_sel = 1'b0;
`endif

    always_comb begin
        pres_mask   = '0;
        out_pc_o    = '0;
        out_insts_o = '0;
        out_excp_o  = '0;
        if (byp_sel) begin
            if (in_valid_i) pres_mask = {in_n == 2'd2, in_n != 2'd0};
            if (pres_mask[0]) begin
                out_pc_o[31:0]    = pk0_pc;
                out_insts_o[31:0] = pk0_inst;
                out_excp_o[0]     = pk0_excp;
            end
            if (pres_mask[1]) begin
                out_pc_o[63:32]    = pk1_pc;
                out_insts_o[63:32] = pk1_inst;
                out_excp_o[1]      = pk1_excp;
            end
        end else begin
            pres_mask = {count >= CNT_TWO, count != '0};
            if (pres_mask[0]) begin
                out_pc_o[31:0]    = pc_mem[rd_ptr];
                out_insts_o[31:0] = inst_mem[rd_ptr];
                out_excp_o[0]     = excp_mem[rd_ptr];
            end
            if (pres_mask[1]) begin
                out_pc_o[63:32]    = pc_mem[rd_ptr_p1];
                out_insts_o[63:32] = inst_mem[rd_ptr_p1];
                out_excp_o[1]      = excp_mem[rd_ptr_p1];
            end
        end
    end

    assign out_mask_o  = pres_mask;
    assign out_valid_o = |pres_mask;
    assign pop_n       = {1'b0, pres_mask[0]} + {1'b0, pres_mask[1]};

    // A bypassed packet that the decoder takes is neither stored nor popped.
    assign do_push = in_valid_i && in_ready_o && !(byp_sel && out_ready_i);
    assign do_pop  = out_valid_o && out_ready_i && !byp_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(in_n);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(pop_n);
            count <= count + (do_push ? (PTR_W+1)'(in_n) : '0)
                           - (do_pop  ? (PTR_W+1)'(pop_n) : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            if (in_n != 2'd0) begin
                pc_mem[wr_ptr]   <= pk0_pc;
                inst_mem[wr_ptr] <= pk0_inst;
                excp_mem[wr_ptr] <= pk0_excp;
            end
            if (in_n == 2'd2) begin
                pc_mem[wr_ptr_p1]   <= pk1_pc;
                inst_mem[wr_ptr_p1] <= pk1_inst;
                excp_mem[wr_ptr_p1] <= pk1_excp;
            end
        end
    end

endmodule

// File: tb/tb_decode_inst_queue.sv
// Scoreboard bench for decode_inst_queue: accepted slots are queued in program order
// and compared against the presented pair every cycle.
module tb_decode_inst_queue;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [31:0]      in_pc_i = '0;
    logic [63:0]      in_insts_i = '0;
    logic [1:0]       in_mask_i = '0;
    logic [1:0]       in_excp_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [1:0]       out_mask_o;
    logic [63:0]      out_pc_o;
    logic [63:0]      out_insts_o;
    logic [1:0]       out_excp_o;
    logic [PTR_W:0]   count_o;

    int   passed = 0;
    int   total  = 0;
    ent_t q[$];

    decode_inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_pc_i(in_pc_i),
        .in_insts_i(in_insts_i), .in_mask_i(in_mask_i), .in_excp_i(in_excp_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_mask_o(out_mask_o),
        .out_pc_o(out_pc_o), .out_insts_o(out_insts_o), .out_excp_o(out_excp_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_pkt(input logic v, input logic [31:0] pc, input logic [1:0] m,
                           input logic rdy);
        in_valid_i  = v;
        in_pc_i     = pc;
        in_mask_i   = m;
        in_insts_i  = {$urandom, $urandom};
        in_excp_i   = 2'($urandom_range(0, 3));
        out_ready_i = rdy;
    endtask

    // One clock: compare presentation at negedge, then retire/accept into the scoreboard.
    task automatic step();
        ent_t       ins[$];
        ent_t       pres[$];
        ent_t       e;
        logic       byp;
        logic [1:0] em;
        logic       er;
        int         popn;
        logic       pushok;
        if (in_mask_i[0]) begin
            e.pc = in_pc_i; e.inst = in_insts_i[31:0]; e.excp = in_excp_i[0];
            ins.push_back(e);
        end
        if (in_mask_i[1]) begin
            e.pc = in_pc_i | 32'h4; e.inst = in_insts_i[63:32]; e.excp = in_excp_i[1];
            ins.push_back(e);
        end
        byp = 1'b0;
`ifdef DECODE_INST_QUEUE_BYPASS_EN
        byp = (q.size() == 0) && !flush_i;
`endif
        @(negedge clk);
        if (byp) begin
            if (in_valid_i) pres = ins;
        end else begin
            for (int i = 0; i < 2 && i < q.size(); i++) pres.push_back(q[i]);
        end
        em = (pres.size() == 2) ? 2'b11 : (pres.size() == 1) ? 2'b01 : 2'b00;
        er = !flush_i && (DEPTH - q.size() >= 2);
        total++;
        if (out_mask_o !== em) $display("FAIL out_mask: got %b expected %b", out_mask_o, em);
        else passed++;
        total++;
        if (out_valid_o !== (em != 2'b00))
            $display("FAIL out_valid: got %b expected %b", out_valid_o, em != 2'b00);
        else passed++;
        total++;
        if (in_ready_o !== er) $display("FAIL in_ready: got %b expected %b", in_ready_o, er);
        else passed++;
        total++;
        if (count_o !== (PTR_W+1)'(q.size()))
            $display("FAIL count: got %0d expected %0d", count_o, q.size());
        else passed++;
        for (int s = 0; s < pres.size(); s++) begin
            total++;
            if (out_pc_o[s*32 +: 32] !== pres[s].pc || out_insts_o[s*32 +: 32] !== pres[s].inst
                || out_excp_o[s] !== pres[s].excp)
                $display("FAIL slot%0d data: got pc=%h inst=%h excp=%b expected pc=%h inst=%h excp=%b",
                         s, out_pc_o[s*32 +: 32], out_insts_o[s*32 +: 32], out_excp_o[s],
                         pres[s].pc, pres[s].inst, pres[s].excp);
            else passed++;
        end
        popn   = (em != 2'b00 && out_ready_i && !byp) ? pres.size() : 0;
        pushok = in_valid_i && er && !(byp && out_ready_i);
        @(posedge clk);
        #1;
        if (flush_i) q.delete();
        else begin
            repeat (popn) void'(q.pop_front());
            if (pushok) foreach (ins[i]) q.push_back(ins[i]);
        end
    endtask

    task automatic test_reset();
        in_valid_i = 1'b1;
        in_mask_i  = 2'b11;
        #3;
        total++;
        if (count_o !== '0 || out_valid_o !== 1'b0 || out_mask_o !== 2'b00 || in_ready_o !== 1'b0)
            $display("FAIL reset_state: got count=%0d valid=%b mask=%b ready=%b expected 0/0/00/0",
                     count_o, out_valid_o, out_mask_o, in_ready_o);
        else passed++;
        @(negedge clk);
        rst        = 1'b0;
        in_valid_i = 1'b0;
        in_mask_i  = 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_push();
        set_pkt(1'b1, 32'h1c000000, 2'b11, 1'b0);
        step();
        set_pkt(1'b0, '0, 2'b00, 1'b0);
        total++;
        if (out_mask_o !== 2'b11 || out_pc_o !== {32'h1c000004, 32'h1c000000} || count_o !== 4'd2)
            $display("FAIL first_push: got mask=%b pc=%h count=%0d expected 11 1c0000041c000000 2",
                     out_mask_o, out_pc_o, count_o);
        else passed++;
        out_ready_i = 1'b1;
        step();
    endtask

    task automatic test_partial_masks();
        set_pkt(1'b1, 32'h100, 2'b10, 1'b0);
        step();
        set_pkt(1'b1, 32'h200, 2'b00, 1'b0);
        step();
        set_pkt(1'b1, 32'h108, 2'b01, 1'b0);
        step();
        set_pkt(1'b0, '0, 2'b00, 1'b0);
        total++;
        if (out_mask_o !== 2'b11 || out_pc_o !== {32'h108, 32'h104})
            $display("FAIL partial_pair: got mask=%b pc=%h expected 11 0000010800000104",
                     out_mask_o, out_pc_o);
        else passed++;
        out_ready_i = 1'b1;
        step();
        total++;
        if (count_o !== '0) $display("FAIL partial_pop: got count=%0d expected 0", count_o);
        else passed++;
    endtask

    task automatic test_full();
        logic [31:0] pc = 32'h4000;
        for (int i = 0; i < 6; i++) begin
            if (!in_ready_o) break;
            set_pkt(1'b1, pc, 2'b11, 1'b0);
            step();
            pc += 8;
        end
        total++;
        if (count_o !== 4'd8 || in_ready_o !== 1'b0)
            $display("FAIL full_block: got count=%0d ready=%b expected 8 0", count_o, in_ready_o);
        else passed++;
        for (int i = 0; i < 2; i++) begin
            set_pkt(1'b1, 32'hdead0000, 2'b11, 1'b0);
            step();
        end
        set_pkt(1'b0, '0, 2'b00, 1'b1);
        step();
        total++;
        if (in_ready_o !== 1'b1 || count_o !== 4'd6)
            $display("FAIL full_release: got ready=%b count=%0d expected 1 6", in_ready_o, count_o);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            if (q.size() == 0) break;
            step();
        end
    endtask

    task automatic test_stream();
        logic [31:0] pc  = 32'h2000;
        logic [31:0] nxt = 32'h2000;
        for (int i = 0; i < 24; i++) begin
            if (i < 20) set_pkt(1'b1, pc, 2'b11, 1'b1);
            else        set_pkt(1'b0, '0, 2'b00, 1'b1);
            if (out_mask_o == 2'b11) begin
                total++;
                if (out_pc_o !== {nxt + 32'h4, nxt})
                    $display("FAIL stream_order: got pc=%h expected %h", out_pc_o, {nxt + 32'h4, nxt});
                else passed++;
                nxt += 8;
            end
            step();
            pc += 8;
        end
        total++;
        if (nxt !== 32'h2000 + 32'd160)
            $display("FAIL stream_total: got next pc %h expected %h", nxt, 32'h2000 + 32'd160);
        else passed++;
    endtask

    task automatic test_flush();
        set_pkt(1'b1, 32'h5000, 2'b11, 1'b0); step();
        set_pkt(1'b1, 32'h5008, 2'b11, 1'b0); step();
        set_pkt(1'b1, 32'h5010, 2'b01, 1'b0); step();
        total++;
        if (count_o !== 4'd5) $display("FAIL flush_setup: got count=%0d expected 5", count_o);
        else passed++;
        set_pkt(1'b1, 32'h9000, 2'b11, 1'b1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        set_pkt(1'b0, '0, 2'b00, 1'b1);
        total++;
        if (count_o !== '0 || out_valid_o !== 1'b0)
            $display("FAIL flush_clear: got count=%0d valid=%b expected 0 0", count_o, out_valid_o);
        else passed++;
        step();
    endtask

    task automatic test_async_reset();
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pkt(1'b1, 32'h6000 + 32'(i * 8), 2'b11, 1'b0);
            step();
        end
        set_pkt(1'b0, '0, 2'b00, 1'b0);
        total++;
        if (count_o !== 4'd6) $display("FAIL areset_setup: got count=%0d expected 6", count_o);
        else passed++;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (count_o !== '0 || out_valid_o !== 1'b0)
            $display("FAIL async_reset: got count=%0d valid=%b expected 0 0", count_o, out_valid_o);
        else passed++;
        q.delete();
        #1;
        rst = 1'b0;
        step();
    endtask

`ifdef DECODE_INST_QUEUE_BYPASS_EN
    task automatic test_bypass();
        set_pkt(1'b1, 32'h7000, 2'b11, 1'b1);
        #1;
        total++;
        if (out_valid_o !== 1'b1 || count_o !== '0 || out_pc_o !== {32'h7004, 32'h7000})
            $display("FAIL bypass_same_cycle: got valid=%b count=%0d pc=%h expected 1 0 0000700400007000",
                     out_valid_o, count_o, out_pc_o);
        else passed++;
        step();
        set_pkt(1'b0, '0, 2'b00, 1'b1);
        total++;
        if (count_o !== '0) $display("FAIL bypass_no_store: got count=%0d expected 0", count_o);
        else passed++;
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_first_push();
        test_partial_masks();
        test_full();
        test_stream();
        test_flush();
        test_async_reset();
`ifdef DECODE_INST_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decode_inst_queue.md
Name: decode_inst_queue

Overview:
- Instruction queue between the fetch stage and the dual-issue decoder.
- Accepts one fetch packet per cycle: aligned PC, two instructions, slot mask and per-slot fetch-exception flags.
- Drops masked-off slots and stores surviving instructions in program order in a circular buffer.
- Presents up to two oldest instructions per cycle to the decoder as a compacted pair: slot 0 is always filled whenever anything is valid.

Parameters:
- DEPTH, 8: number of single-instruction entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH): pointer width, derived.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-high
- flush_i  input  1  pipeline flush (branch mispredict / exception redirect)
- in_valid_i  input  1  fetch packet valid
- in_ready_o  output  1  queue can accept a full packet
- in_pc_i  input  32  PC of slot 0; slot 1 PC = in_pc_i | 32'h4
- in_insts_i  input  64  [31:0] slot 0, [63:32] slot 1
- in_mask_i  input  2  per-slot valid
- in_excp_i  input  2  per-slot fetch exception flag
- out_valid_o  output  1  at least one instruction presented
- out_ready_i  input  1  decoder accepts all presented instructions
- out_mask_o  output  2  presented slots; only 00, 01 or 11
- out_pc_o  output  64  PCs of slots 0/1
- out_insts_o  output  64  instructions of slots 0/1
- out_excp_o  output  2  exception flags of slots 0/1
- count_o  output  PTR_W+1  current occupancy

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: out_valid_o=0, out_mask_o=00, count_o=0, in_ready_o=0 while rst is high.
  - Entry storage is not reset.
- in_ready_o = !flush_i && (DEPTH - count >= 2). It uses the registered count only; same-cycle pops are not credited.
- Push (in_valid_i && in_ready_o): write popcount(in_mask_i) entries at wr_ptr, wr_ptr+1, in slot order.
  - Each entry stores {pc, inst, excp}. Slot 1 pc = in_pc_i | 4.
  - Mask 10 writes only slot 1, to wr_ptr.
  - Mask 00 is accepted and writes nothing.
- Presentation (combinational from registered state):
  - out_mask_o[0] = count>=1; out_mask_o[1] = count>=2; out_valid_o = |out_mask_o.
  - Slot 0 = entry[rd_ptr]; slot 1 = entry[rd_ptr+1].
  - Unmasked slot data is don't-care but must be driven: 0 for excp.
- Pop (out_valid_o && out_ready_i): rd_ptr += popcount(out_mask_o). There is no partial consumption.
- Pointer arithmetic: modulo DEPTH; wrap is natural PTR_W-bit overflow. A packet may straddle the wrap point.
- Simultaneous push and pop: count_next = count + pushed - popped. The storage write and read never collide, because a push requires 2 free entries.
- Latency: a pushed instruction is presented the cycle after the push edge; 1-cycle minimum, without the optional feature.
- Flush: synchronous, highest priority.
  - On a clk edge with flush_i=1: wr_ptr=rd_ptr=0 and count=0. Any same-cycle push or pop is discarded.
  - During the flush cycle out_valid_o still reflects the old contents; the decoder side must ignore them under flush.
- Full: count > DEPTH-2 drops in_ready_o; the fetch stage holds its packet.
- Empty: out_valid_o=0, and out_ready_i is ignored.
- Reset mid-operation clears state immediately, regardless of the clock.

Optional Feature:
- Macro: DECODE_INST_QUEUE_BYPASS_EN
- Defined:
  - When count==0 and flush_i=0, the compacted input packet drives the outputs in the same cycle: out_mask_o from popcount(in_mask_i), and out_valid_o = in_valid_i && |in_mask_i.
  - If out_ready_i=1, nothing is written and pointers are unchanged.
  - If out_ready_i=0, the packet is pushed normally.
  - Latency becomes 0 cycles when empty.
- Undefined: no bypass path; outputs come from storage only, with 1-cycle minimum latency.

Test Plan:
- Reset, then push pc=0x1c000000 with mask 11 and out_ready_i=0 -> next cycle out_mask_o=11, out_pc_o={0x1c000004,0x1c000000}, count_o=2.
- Push pc=0x100 mask 10, then pc=0x108 mask 01 -> presented pair pcs {0x108,0x104}, out_mask_o=11; pop -> count_o=0.
- out_ready_i=0, push mask-11 packets until blocked -> in_ready_o=0 at count_o=DEPTH (8); hold in_valid_i -> no overwrite. Pop one pair -> in_ready_o=1 next cycle.
- Stream of 20 mask-11 packets with out_ready_i=1 throughout -> pointers wrap; output PC sequence is strictly +4 with no gaps or duplicates.
- Occupancy 5 with push and pop in the same cycle as flush_i=1 -> next cycle count_o=0, out_valid_o=0, and the pushed packet is not presented.
- Assert rst asynchronously mid-stream at occupancy 6 -> count_o=0 and out_valid_o=0 before the next clk edge.
- With DECODE_INST_QUEUE_BYPASS_EN, empty queue, push mask 11, out_ready_i=1 -> same-cycle out_valid_o=1 and count_o stays 0.
